// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a Mealy match flag, its registered
// copy, and a saturating match counter. Overlap mode is selectable at run time.
module seq_detect_param #(
  parameter int             N       = 3,       // pattern length, legal range 2..16
  parameter logic [N-1:0]   PATTERN = 3'b101,  // bit N-1 oldest, bit 0 newest
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int             FW       = $clog2(N);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

  logic [N-2:0]     hist, hist_nxt;
  logic [FW-1:0]    fill, fill_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [N-1:0]     win;
  logic             match;

  // Candidate window: stored history plus the bit arriving this cycle.
  assign win = {hist, x};

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist      <= '0;
      fill      <= '0;
      z_q       <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      z_q       <= z;
      match_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    cnt_nxt  = match_cnt;
    if (en) begin
      hist_nxt = win[N-2:0];
      // Non-overlap restarts the window; otherwise fill climbs and parks at N-1.
      if (match && !overlap)
        fill_nxt = '0;
      else if (fill != FILL_MAX)
        fill_nxt = fill + FW'(1);
      // Clear is an accepted-cycle action and wins over a coincident match.
      if (clr_cnt)
        cnt_nxt = '0;
      else if (match && (match_cnt != {CNT_W{1'b1}}))
        cnt_nxt = match_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    match = en && reset && (fill == FILL_MAX) && (win == PATTERN);
    z     = match;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised bench for seq_detect_param: three instances (default, narrow counter,
// 4-bit pattern) share one stimulus stream and are scored against a queue-based model.
module tb_seq_detect_param;

  localparam int W = 24;

  logic       clk = 1'b0;
  logic       reset, en, x, overlap, clr_cnt;
  logic       z_a, z_b, z_c, zq_a, zq_b, zq_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: accepted bits since the last reset or non-overlap match.
  bit hist_q[3][$];
  int m_cnt[3];
  int m_n[3]   = '{3, 3, 4};
  int m_pat[3] = '{5, 5, 13};
  int m_max[3] = '{255, 3, 255};

  always #5 clk = ~clk;

  seq_detect_param #(.N(3), .PATTERN(3'b101), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z_a), .z_q(zq_a), .match_cnt(cnt_a));

  seq_detect_param #(.N(3), .PATTERN(3'b101), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z_b), .z_q(zq_b), .match_cnt(cnt_b));

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z_c), .z_q(zq_c), .match_cnt(cnt_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit e, input bit xb,
                            input bit ov, input bit clr, output bit m);
    m = 1'b0;
    if (!r) begin
      hist_q[i].delete();
      m_cnt[i] = 0;
    end else if (e) begin
      hist_q[i].push_back(xb);
      if (hist_q[i].size() > m_n[i]) void'(hist_q[i].pop_front());
      if (hist_q[i].size() == m_n[i]) begin
        m = 1'b1;
        for (int k = 0; k < m_n[i]; k++)
          if (hist_q[i][k] != m_pat[i][m_n[i]-1-k]) m = 1'b0;
      end
      if (m && !ov) hist_q[i].delete();
      if (clr) m_cnt[i] = 0;
      else if (m && m_cnt[i] < m_max[i]) m_cnt[i]++;
    end
  endtask

  // One cycle of stimulus; expected z this cycle and z_q/count after the edge.
  task automatic drive(input bit r, input bit e, input bit xb, input bit ov, input bit clr);
    bit m0, m1, m2;
    logic [7:0] c0, c2;
    logic [1:0] c1;
    @(posedge clk);
    #1;
    reset = r; en = e; x = xb; overlap = ov; clr_cnt = clr;
    model_step(0, r, e, xb, ov, clr, m0);
    model_step(1, r, e, xb, ov, clr, m1);
    model_step(2, r, e, xb, ov, clr, m2);
    c0 = m_cnt[0][7:0];
    c1 = m_cnt[1][1:0];
    c2 = m_cnt[2][7:0];
    exp_q.push_back({m0, m1, m2, m0, m1, m2, c0, c1, c2});
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  // Bits are sent MSB first; gap inserts an idle cycle with random x after each bit.
  task automatic run_bits(input logic [15:0] v, input int len, input bit ov, input bit gap);
    for (int i = len - 1; i >= 0; i--) begin
      drive(1'b1, 1'b1, v[i], ov, 1'b0);
      if (gap) idle();
    end
  endtask

  // Monitor: pops one entry per cycle the driver issued.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("z_a", 32'(z_a), 32'(e[23]));
        check("z_b", 32'(z_b), 32'(e[22]));
        check("z_c", 32'(z_c), 32'(e[21]));
        @(posedge clk);
        #1;
        check("zq_a", 32'(zq_a), 32'(e[20]));
        check("zq_b", 32'(zq_b), 32'(e[19]));
        check("zq_c", 32'(zq_c), 32'(e[18]));
        check("cnt_a", 32'(cnt_a), 32'(e[17:10]));
        check("cnt_b", 32'(cnt_b), 32'(e[9:8]));
        check("cnt_c", 32'(cnt_c), 32'(e[7:0]));
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; x = 1'b0; overlap = 1'b0; clr_cnt = 1'b0;

    do_reset();
    run_bits(16'b010101101, 9, 1'b0, 1'b0);
    idle();
    check("nonoverlap_final_cnt", 32'(cnt_a), 32'd2);

    do_reset();
    run_bits(16'b010101101, 9, 1'b1, 1'b0);
    idle();
    check("overlap_final_cnt", 32'(cnt_a), 32'd3);

    do_reset();
    run_bits(16'b010101101, 9, 1'b0, 1'b1);
    idle();
    check("gap_final_cnt", 32'(cnt_a), 32'd2);

    do_reset();
    run_bits(16'b101010101, 9, 1'b1, 1'b0);
    idle();
    check("sat_cnt_b", 32'(cnt_b), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("clr_match_z_b", 32'(z_b), 32'd1);
    idle();
    check("clr_cnt_b", 32'(cnt_b), 32'd0);

    do_reset();
    run_bits(16'b10, 2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("post_reset_no_match", 32'(z_a), 32'd0);
    run_bits(16'b01, 2, 1'b0, 1'b0);
    idle();
    check("post_reset_cnt", 32'(cnt_a), 32'd1);

    do_reset();
    run_bits(16'b1101101, 7, 1'b1, 1'b0);
    idle();
    check("wide_final_cnt", 32'(cnt_c), 32'd2);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, e;
      r = ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 9) < 7);
      drive(r, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            e && ($urandom_range(0, 19) == 0));
    end
    idle();

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain_q", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
